// File: rtl/mem_arbiter.sv
// Three-port arbiter (PPU > CPU > host, with host anti-starvation) in front of one
// shared memory port. One access in flight: IDLE grants, ISSUE waits for mem_ack, DONE acks.
module mem_arbiter #(
  parameter int ADDR_BITS     = 23,
  parameter int DATA_BITS     = 8,
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ppu_req,
  input  logic                 ppu_we,
  input  logic [ADDR_BITS-1:0] ppu_addr,
  input  logic [DATA_BITS-1:0] ppu_wdata,
  output logic                 ppu_ack,
  output logic [DATA_BITS-1:0] ppu_rdata,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATA_BITS-1:0] cpu_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_wdata,
  output logic                 host_ack,
  output logic [DATA_BITS-1:0] host_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic [1:0]           owner
);

  localparam int WW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PPU  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_HOST = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state_q;
  logic [WW-1:0]        wait_q;
  logic [1:0]           win_d;
  logic                 sel_we_d;
  logic [ADDR_BITS-1:0] sel_addr_d;
  logic [DATA_BITS-1:0] sel_wdata_d;

  // Host overrides the fixed priority once it has lost HOST_MAX_WAIT grants in a row.
  always_comb begin
    win_d = OWN_NONE;
    if (host_req && wait_q == WAIT_MAX) win_d = OWN_HOST;
    else if (ppu_req)                   win_d = OWN_PPU;
    else if (cpu_req)                   win_d = OWN_CPU;
    else if (host_req)                  win_d = OWN_HOST;
  end

  always_comb begin
    sel_we_d    = host_we;
    sel_addr_d  = host_addr;
    sel_wdata_d = host_wdata;
    case (win_d)
      OWN_PPU: begin
        sel_we_d    = ppu_we;
        sel_addr_d  = ppu_addr;
        sel_wdata_d = ppu_wdata;
      end
      OWN_CPU: begin
        sel_we_d    = cpu_we;
        sel_addr_d  = cpu_addr;
        sel_wdata_d = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ppu_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      ppu_rdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      busy       <= 1'b0;
      owner      <= OWN_NONE;
    end else begin
      ppu_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!host_req || win_d == OWN_HOST) wait_q <= '0;
          else if (wait_q != WAIT_MAX)        wait_q <= wait_q + WW'(1);
          if (win_d != OWN_NONE) begin
            state_q   <= ISSUE;
            owner     <= win_d;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= sel_we_d;
            mem_addr  <= sel_addr_d;
            mem_wdata <= sel_wdata_d;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= DONE;
            case (owner)
              OWN_PPU: begin
                ppu_ack <= 1'b1;
                if (!mem_we) ppu_rdata <= mem_rdata;
              end
              OWN_CPU: begin
                cpu_ack <= 1'b1;
                if (!mem_we) cpu_rdata <= mem_rdata;
              end
              OWN_HOST: begin
                host_ack <= 1'b1;
                if (!mem_we) host_rdata <= mem_rdata;
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          // Requesters see their ack this cycle and drop req, so nothing is sampled here.
          state_q <= IDLE;
          busy    <= 1'b0;
          owner   <= OWN_NONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the basic flows, then
// hand-written sequences for host write, host anti-starvation and reset mid-access.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        ppu_req, ppu_we, cpu_req, cpu_we, host_req, host_we;
  logic [22:0] ppu_addr, cpu_addr, host_addr;
  logic [7:0]  ppu_wdata, cpu_wdata, host_wdata;
  logic        ppu_ack, cpu_ack, host_ack;
  logic [7:0]  ppu_rdata, cpu_rdata, host_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_BITS(23), .DATA_BITS(8), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  req;     // {host, cpu, ppu}
    logic        mack;
    logic [7:0]  mrd;
    logic        e_mreq;
    logic [1:0]  e_own;
    logic        e_busy;
    logic [2:0]  e_ack;   // {host, cpu, ppu}
    logic [22:0] e_addr;
    logic [23:0] e_rd;    // {host, cpu, ppu}
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [2:0] req, input logic mack, input logic [7:0] mrd,
                              input logic e_mreq, input logic [1:0] e_own, input logic e_busy,
                              input logic [2:0] e_ack, input logic [22:0] e_addr,
                              input logic [23:0] e_rd);
    vec_t v;
    v.req = req; v.mack = mack; v.mrd = mrd; v.e_mreq = e_mreq; v.e_own = e_own;
    v.e_busy = e_busy; v.e_ack = e_ack; v.e_addr = e_addr; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return {10'd0, mem_req, owner, busy, host_ack, cpu_ack, ppu_ack, mem_addr,
            host_rdata, cpu_rdata, ppu_rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_ppu, n_host;
  int ppu_runs [2];

  initial begin
    rst_n = 1'b0;
    {ppu_req, ppu_we, cpu_req, cpu_we, host_req, host_we, mem_ack} = '0;
    ppu_addr  = 23'h00100;  ppu_wdata  = 8'h01;
    cpu_addr  = 23'h04123;  cpu_wdata  = 8'h02;
    host_addr = 23'h7FFFFF; host_wdata = 8'h03;
    mem_rdata = 8'h00;

    // idle, stray ack, single CPU read, PPU vs CPU, host queued during an access
    tbl[0]  = mk(3'b000, 1'b1, 8'hFF, 1'b0, 2'd0, 1'b0, 3'b000, 23'h0,      24'h000000);
    tbl[1]  = mk(3'b010, 1'b0, 8'h00, 1'b1, 2'd2, 1'b1, 3'b000, 23'h04123,  24'h000000);
    tbl[2]  = mk(3'b010, 1'b0, 8'h00, 1'b1, 2'd2, 1'b1, 3'b000, 23'h04123,  24'h000000);
    tbl[3]  = mk(3'b010, 1'b1, 8'hA5, 1'b0, 2'd2, 1'b1, 3'b010, 23'h04123,  24'h00A500);
    tbl[4]  = mk(3'b000, 1'b1, 8'h77, 1'b0, 2'd0, 1'b0, 3'b000, 23'h04123,  24'h00A500);
    tbl[5]  = mk(3'b011, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 3'b000, 23'h00100,  24'h00A500);
    tbl[6]  = mk(3'b011, 1'b1, 8'h11, 1'b0, 2'd1, 1'b1, 3'b001, 23'h00100,  24'h00A511);
    tbl[7]  = mk(3'b010, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 23'h00100,  24'h00A511);
    tbl[8]  = mk(3'b110, 1'b0, 8'h00, 1'b1, 2'd2, 1'b1, 3'b000, 23'h04123,  24'h00A511);
    tbl[9]  = mk(3'b110, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1, 3'b010, 23'h04123,  24'h002211);
    tbl[10] = mk(3'b100, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 23'h04123,  24'h002211);
    tbl[11] = mk(3'b100, 1'b0, 8'h00, 1'b1, 2'd3, 1'b1, 3'b000, 23'h7FFFFF, 24'h002211);
    tbl[12] = mk(3'b100, 1'b1, 8'h33, 1'b0, 2'd3, 1'b1, 3'b100, 23'h7FFFFF, 24'h332211);
    tbl[13] = mk(3'b000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'b000, 23'h7FFFFF, 24'h332211);

    #12;
    chk("reset_state", snap(), 64'd0);
    chk("reset_wr", {55'd0, mem_we, mem_wdata}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      {host_req, cpu_req, ppu_req} = tbl[i].req;
      mem_ack   = tbl[i].mack;
      mem_rdata = tbl[i].mrd;
      tick();
      chk($sformatf("row%0d", i), snap(),
          {10'd0, tbl[i].e_mreq, tbl[i].e_own, tbl[i].e_busy, tbl[i].e_ack,
           tbl[i].e_addr, tbl[i].e_rd});
    end

    // host write: fields reach the memory port, rdata untouched
    host_we = 1'b1; host_wdata = 8'h3C; host_req = 1'b1; mem_ack = 1'b0;
    tick();
    chk("hwr_issue", {30'd0, mem_req, mem_we, mem_wdata, mem_addr, owner},
        {30'd0, 1'b1, 1'b1, 8'h3C, 23'h7FFFFF, 2'd3});
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    chk("hwr_done", {55'd0, host_ack, host_rdata}, {55'd0, 1'b1, 8'h33});
    host_req = 1'b0; host_we = 1'b0; mem_ack = 1'b0;
    tick();
    chk("hwr_idle", {59'd0, host_ack, busy, owner, mem_req}, 64'd0);

    // host anti-starvation: PPU held, host held, zero-latency memory
    ppu_req = 1'b1; host_req = 1'b1; mem_rdata = 8'h5A;
    n_ppu = 0; n_host = 0;
    for (int c = 0; c < 200 && n_host < 2; c++) begin
      mem_ack = mem_req;
      tick();
      if (ppu_ack) n_ppu++;
      if (host_ack) begin
        ppu_runs[n_host] = n_ppu;
        n_host++;
        n_ppu = 0;
      end
    end
    chk("starve_hostgrants", 64'(n_host), 64'd2);
    if (n_host == 2) begin
      chk("starve_run1", 64'(ppu_runs[0]), 64'd4);
      chk("starve_run2", 64'(ppu_runs[1]), 64'd4);
    end
    ppu_req = 1'b0; host_req = 1'b0; mem_ack = 1'b0;
    repeat (3) tick();
    chk("starve_idle", {60'd0, busy, owner, mem_req}, 64'd0);

    // reset while the access is outstanding, then a late mem_ack
    cpu_req = 1'b1;
    tick();
    chk("rst_issue", {61'd0, mem_req, owner}, {61'd0, 1'b1, 2'd2});
    #2 rst_n = 1'b0; cpu_req = 1'b0;
    #1 chk("rst_async", snap(), 64'd0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_lateack", snap(), 64'd0);
    tick();
    chk("rst_lateack2", {55'd0, mem_we, mem_wdata}, 64'd0);
    mem_ack = 1'b0;

    // stray ack in idle after everything
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("stray_idle", snap(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 23, memory word address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, data width.
REQ-003 SHALL have parameter HOST_MAX_WAIT, default 16, count of lost host arbitrations before the host is forced to win.
REQ-004 SHALL have port clk  in  1  single clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports ppu_req/ppu_we  in  1  PPU (CHR) request level and write flag.
REQ-007 SHALL have ports ppu_addr  in  ADDR_BITS and ppu_wdata  in  DATA_BITS.
REQ-008 SHALL have ports ppu_ack  out  1  one-cycle completion pulse, and ppu_rdata  out  DATA_BITS.
REQ-009 SHALL have the identical set cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack, cpu_rdata (PRG/WRAM).
REQ-010 SHALL have the identical set host_req, host_we, host_addr, host_wdata, host_ack, host_rdata (MCU loader).
REQ-011 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_BITS, mem_wdata  out  DATA_BITS: single shared memory port.
REQ-012 SHALL have ports mem_ack  in  1  one-cycle completion pulse, and mem_rdata  in  DATA_BITS  valid with mem_ack.
REQ-013 SHALL have ports busy  out  1 and owner  out  2  (0 none, 1 PPU, 2 CPU, 3 host).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-015 IDLE: if any *_req high, SHALL latch winner's we/addr/wdata, set owner, enter ISSUE; otherwise stay.
REQ-016 Priority SHALL be PPU > CPU > host, except host wins when wait counter == HOST_MAX_WAIT and host_req high.
REQ-017 ISSUE: mem_req SHALL be high with latched fields stable until mem_ack sampled high; then enter DONE.
REQ-018 mem_req SHALL be registered: request seen in IDLE at cycle t gives mem_req high at t+1.
REQ-019 On mem_ack in ISSUE, owner's *_rdata SHALL load mem_rdata (reads only; writes leave rdata unchanged).
REQ-020 DONE: owner's *_ack SHALL be high exactly one cycle (the cycle after mem_ack); then enter IDLE.
REQ-021 Requesters drop *_req the cycle *_ack is seen; DONE SHALL sample no requests, preventing duplicate grants.
REQ-022 *_rdata SHALL hold its value until that port's next read completes.
REQ-023 Wait counter SHALL increment (saturating at HOST_MAX_WAIT) on each IDLE grant to PPU/CPU while host_req high.
REQ-024 Wait counter SHALL clear on host grant or whenever host_req is low in IDLE.
REQ-025 mem_ack while in IDLE or DONE SHALL be ignored.
REQ-026 Requests arriving during ISSUE/DONE SHALL wait; none is lost while its req stays high.
REQ-027 busy SHALL be high in ISSUE and DONE; owner SHALL be 0 in IDLE.
REQ-028 Minimum grant-to-grant spacing SHALL be 3 cycles with zero-latency memory (IDLE, ISSUE, DONE).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all *_ack=0, all *_rdata=0, wait counter=0, busy=0, owner=0.
REQ-030 Reset during ISSUE SHALL abandon the access; a later mem_ack SHALL be ignored and no *_ack issued.

Verification
REQ-031 Single CPU read addr 0x4123, mem_ack 2 cycles after mem_req with mem_rdata 0xA5 -> cpu_ack one cycle later, cpu_rdata=0xA5, owner 2 then 0.
REQ-032 PPU and CPU req same cycle -> PPU served first, CPU granted on next IDLE; each ack exactly once.
REQ-033 PPU held continuously with host_req high, HOST_MAX_WAIT=4 -> host granted after 4 PPU grants, counter clears.
REQ-034 Host write addr 0x7FFFFF data 0x3C -> mem_we=1, mem_wdata=0x3C; host_ack pulses; host_rdata unchanged.
REQ-035 rst_n low mid-ISSUE then mem_ack -> all outputs reset values, no *_ack, FSM IDLE.
REQ-036 Stray mem_ack in IDLE with no requests -> no state change, all acks low.
